// File: rtl/hcm_event_sequencer_if.sv
// HCM memory port bundle: the sequencer issues write/read/clear commands,
// the HCM returns its status flags and the registered read result.
interface hcm_event_sequencer_if #(
  parameter int ROWINDEXBITS_HCM = 16,
  parameter int NCOLS_HCM        = 32
);
  logic                        hcm_writeRow;
  logic [ROWINDEXBITS_HCM-1:0] hcm_rowToWrite;
  logic                        hcm_SSIDIsNew;
  logic                        hcm_readRow;
  logic [ROWINDEXBITS_HCM-1:0] hcm_rowToRead;
  logic                        hcm_reset;
  logic                        hcm_writeReady;
  logic                        hcm_readReady;
  logic                        hcm_busy;
  logic [ROWINDEXBITS_HCM-1:0] hcm_rowPassed;
  logic [NCOLS_HCM-1:0]        hcm_rowReadOutput;

  modport master (
    output hcm_writeRow, hcm_rowToWrite, hcm_SSIDIsNew,
    output hcm_readRow, hcm_rowToRead, hcm_reset,
    input  hcm_writeReady, hcm_readReady, hcm_busy,
    input  hcm_rowPassed, hcm_rowReadOutput
  );

  modport slave (
    input  hcm_writeRow, hcm_rowToWrite, hcm_SSIDIsNew,
    input  hcm_readRow, hcm_rowToRead, hcm_reset,
    output hcm_writeReady, hcm_readReady, hcm_busy,
    output hcm_rowPassed, hcm_rowReadOutput
  );
endinterface

// File: rtl/hcm_event_sequencer.sv
// Event sequencer for the hit-count memory: buffers SSID hits and writes them
// into the HCM, drains on event end, serves pipelined row readout, then clears
// the HCM and counts the completed event.
module hcm_event_sequencer #(
  parameter int ROWINDEXBITS_HCM = 16,
  parameter int NCOLS_HCM        = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int READ_LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hit_valid,
  input  logic [ROWINDEXBITS_HCM-1:0] hit_row,
  input  logic                        hit_is_new,
  output logic                        hit_ready,
  input  logic                        event_end,
  input  logic                        rd_req,
  input  logic [ROWINDEXBITS_HCM-1:0] rd_row,
  output logic                        rd_ready,
  input  logic                        readout_done,
  output logic                        rd_valid,
  output logic [ROWINDEXBITS_HCM-1:0] rd_row_out,
  output logic [NCOLS_HCM-1:0]        rd_data,
  hcm_event_sequencer_if.master       hcm,
  output logic [1:0]                  phase,
  output logic [7:0]                  event_count,
  output logic                        err_protocol
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } phase_t;

  phase_t state, stateNext;

  logic [ROWINDEXBITS_HCM:0] fifoMem [FIFO_DEPTH];
  logic [ROWINDEXBITS_HCM:0] fifoHead;
  logic [PW-1:0]             wrPtr, rdPtr;
  logic [CW-1:0]             count, countNext;
  logic                      fifoEmpty, push, pop;

  // rdPipe[0] is the HCM read strobe; the top stage lines up with valid HCM data.
  logic [READ_LATENCY:0]     rdPipe;
  logic                      accept, readsIdle, donePending, doneReq;

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WRITE;
    else       state <= stateNext;
  end

  // Phase transitions; readout_done is honoured only after the read pipeline empties.
  always_comb begin
    stateNext = state;
    unique case (state)
      WRITE: if (event_end)                        stateNext = DRAIN;
      DRAIN: if (fifoEmpty && !pop)                stateNext = READ;
      READ:  if (doneReq && readsIdle)             stateNext = CLEAR;
      CLEAR: if (!hcm.hcm_reset && !hcm.hcm_busy)  stateNext = WRITE;
      default:                                     stateNext = WRITE;
    endcase
  end

  // Handshakes, FIFO pop and HCM write port, all decoded from the current phase.
  always_comb begin
    phase     = state;
    fifoEmpty = (count == '0);
    fifoHead  = fifoMem[rdPtr];
    push      = hit_valid && hit_ready;
    pop       = !fifoEmpty && ((state == WRITE) || (state == DRAIN))
                && hcm.hcm_writeReady && !hcm.hcm_busy;
    rd_ready  = (state == READ) && hcm.hcm_readReady && !hcm.hcm_busy && !donePending;
    accept    = rd_req && rd_ready;
    readsIdle = !accept && (rdPipe == '0);
    doneReq   = donePending || (readout_done && (state == READ));
    unique case ({push, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
    hcm.hcm_writeRow   = pop;
    hcm.hcm_rowToWrite = pop ? fifoHead[ROWINDEXBITS_HCM-1:0] : '0;
    hcm.hcm_SSIDIsNew  = pop && fifoHead[ROWINDEXBITS_HCM];
    hcm.hcm_readRow    = rdPipe[0];
  end

  // Hit storage; never reset because count qualifies every read of it.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= {hit_is_new, hit_row};
  end

  // FIFO pointers and hit_ready; hit_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      hit_ready <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count     <= countNext;
      hit_ready <= (stateNext == WRITE) && (countNext < CW'(FIFO_DEPTH));
    end
  end

  // Read pipeline, result capture and pending readout_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPipe            <= '0;
      hcm.hcm_rowToRead <= '0;
      rd_valid          <= 1'b0;
      rd_row_out        <= '0;
      rd_data           <= '0;
      donePending       <= 1'b0;
    end else begin
      rdPipe            <= {rdPipe[READ_LATENCY-1:0], accept};
      hcm.hcm_rowToRead <= accept ? rd_row : '0;
      rd_valid          <= rdPipe[READ_LATENCY];
      if (rdPipe[READ_LATENCY]) begin
        rd_row_out <= hcm.hcm_rowPassed;
        rd_data    <= hcm.hcm_rowReadOutput;
      end
      if (stateNext == CLEAR)                    donePending <= 1'b0;
      else if (readout_done && (state == READ))  donePending <= 1'b1;
    end
  end

  // HCM clear pulse, event counter and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcm.hcm_reset <= 1'b0;
      event_count   <= '0;
      err_protocol  <= 1'b0;
    end else begin
      hcm.hcm_reset <= (stateNext == CLEAR) && (state != CLEAR);
      if ((state == CLEAR) && (stateNext == WRITE)) event_count <= event_count + 8'd1;
      if ((event_end && (state != WRITE)) || (readout_done && (state != READ))
          || (rd_req && (state != READ)))
        err_protocol <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hcm_event_sequencer.sv
// Directed bench for hcm_event_sequencer with a queue scoreboard for HCM
// writes and readout results, plus a simple fixed-latency HCM read model.
module tb_hcm_event_sequencer;
  localparam int RB    = 16;
  localparam int NC    = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hit_valid = 1'b0, hit_is_new = 1'b0, hit_ready;
  logic [RB-1:0] hit_row = '0;
  logic          event_end = 1'b0;
  logic          rd_req = 1'b0, rd_ready;
  logic [RB-1:0] rd_row = '0;
  logic          readout_done = 1'b0;
  logic          rd_valid;
  logic [RB-1:0] rd_row_out;
  logic [NC-1:0] rd_data;
  logic [1:0]    phase;
  logic [7:0]    event_count;
  logic          err_protocol;

  hcm_event_sequencer_if #(.ROWINDEXBITS_HCM(RB), .NCOLS_HCM(NC)) hif ();

  hcm_event_sequencer #(
    .ROWINDEXBITS_HCM(RB), .NCOLS_HCM(NC), .FIFO_DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_is_new(hit_is_new), .hit_ready(hit_ready),
    .event_end(event_end),
    .rd_req(rd_req), .rd_row(rd_row), .rd_ready(rd_ready),
    .readout_done(readout_done),
    .rd_valid(rd_valid), .rd_row_out(rd_row_out), .rd_data(rd_data),
    .hcm(hif),
    .phase(phase), .event_count(event_count), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NC-1:0] dataOf(input logic [RB-1:0] r);
    return {r ^ 16'hC3A5, ~r};
  endfunction

  // HCM read model: data valid LAT cycles after the read strobe.
  logic          p0v = 1'b0, p1v = 1'b0;
  logic [RB-1:0] p0r = '0, p1r = '0;
  always @(posedge clk) begin
    p0v <= hif.hcm_readRow; p0r <= hif.hcm_rowToRead;
    p1v <= p0v;             p1r <= p0r;
  end
  assign hif.hcm_rowPassed     = p1v ? p1r : '0;
  assign hif.hcm_rowReadOutput = p1v ? dataOf(p1r) : '0;

  logic hcmWriteReady = 1'b1, hcmReadReady = 1'b1, hcmBusy = 1'b0;
  assign hif.hcm_writeReady = hcmWriteReady;
  assign hif.hcm_readReady  = hcmReadReady;
  assign hif.hcm_busy       = hcmBusy;

  typedef struct { logic [RB-1:0] row; logic isNew; } wr_t;
  typedef struct { logic [RB-1:0] row; int cyc; } rd_t;
  wr_t wrQ[$];
  rd_t rdQ[$];

  int nCompared = 0, nMismatched = 0;
  int writesSeen = 0, validsSeen = 0, resetPulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  wr_t      wExp, wNew;
  rd_t      rExp, rNew;
  logic          prevAcc = 1'b0;
  logic [RB-1:0] prevRow = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (hif.hcm_writeRow) begin
        writesSeen++;
        if (wrQ.size() == 0) check("write_unexpected", hif.hcm_writeRow, 1'b0);
        else begin
          wExp = wrQ.pop_front();
          check("write_row", hif.hcm_rowToWrite, wExp.row);
          check("write_isnew", hif.hcm_SSIDIsNew, wExp.isNew);
        end
      end
      if (hif.hcm_writeRow && hif.hcm_readRow) check("wr_rd_overlap", hif.hcm_readRow, 1'b0);
      if (prevAcc || hif.hcm_readRow) begin
        check("readrow_pulse", hif.hcm_readRow, prevAcc);
        if (prevAcc) check("readrow_row", hif.hcm_rowToRead, prevRow);
      end
      if (rd_valid) begin
        validsSeen++;
        if (rdQ.size() == 0) check("rdvalid_unexpected", rd_valid, 1'b0);
        else begin
          rExp = rdQ.pop_front();
          check("rd_row_out", rd_row_out, rExp.row);
          check("rd_data", rd_data, dataOf(rExp.row));
          check("rd_latency", cyc, rExp.cyc + LAT + 2);
        end
      end
      if (hif.hcm_reset) resetPulses++;
      if (hit_valid && hit_ready) begin
        wNew.row = hit_row; wNew.isNew = hit_is_new; wrQ.push_back(wNew);
      end
      prevAcc = rd_req && rd_ready;
      prevRow = rd_row;
      if (prevAcc) begin
        rNew.row = rd_row; rNew.cyc = cyc; rdQ.push_back(rNew);
      end
    end else begin
      prevAcc = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendHit(input logic [RB-1:0] r, input logic n);
    int k = 0;
    hit_valid = 1'b1; hit_row = r; hit_is_new = n;
    @(negedge clk);
    while (!hit_ready && k < 100) begin @(negedge clk); k++; end
    if (!hit_ready) check("hit_accept_timeout", hit_ready, 1'b1);
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  task automatic pulseEventEnd();
    event_end = 1'b1; tick(); event_end = 1'b0;
  endtask

  task automatic waitPhase(input logic [1:0] p, input string tag);
    int k = 0;
    while (phase !== p && k < 200) begin @(negedge clk); k++; end
    check(tag, phase, p);
  endtask

  task automatic checkReset(input string pfx);
    check({pfx, "_phase"}, phase, 2'd0);
    check({pfx, "_hit_ready"}, hit_ready, 1'b0);
    check({pfx, "_event_count"}, event_count, 8'd0);
    check({pfx, "_err"}, err_protocol, 1'b0);
    check({pfx, "_hcm_reset"}, hif.hcm_reset, 1'b0);
    check({pfx, "_rd_valid"}, rd_valid, 1'b0);
    check({pfx, "_rd_ready"}, rd_ready, 1'b0);
    check({pfx, "_rd_data"}, rd_data, '0);
    check({pfx, "_writeRow"}, hif.hcm_writeRow, 1'b0);
    check({pfx, "_readRow"}, hif.hcm_readRow, 1'b0);
  endtask

  int w0, v0, r0;
  logic [RB-1:0] rows4 [4];
  logic          news4 [4];

  initial begin
    rows4[0] = 16'd3; rows4[1] = 16'd1; rows4[2] = 16'd1; rows4[3] = 16'd65534;
    news4[0] = 1'b1;  news4[1] = 1'b0;  news4[2] = 1'b0;  news4[3] = 1'b1;

    // Reset state and first edge after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("rst");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_release_before_edge", hit_ready, 1'b0);
    tick();
    check("rst_first_edge_hit_ready", hit_ready, 1'b1);

    // Four hits written in order.
    w0 = writesSeen;
    for (int i = 0; i < 4; i++) sendHit(rows4[i], news4[i]);
    tick(6);
    check("req034_write_count", writesSeen - w0, 4);
    check("req034_queue_empty", wrQ.size(), 0);

    // Full FIFO backpressure, ninth hit after first pop.
    hcmWriteReady = 1'b0;
    w0 = writesSeen;
    for (int i = 0; i < 8; i++) sendHit(RB'(256 + i), 1'(i));
    hit_valid = 1'b1; hit_row = 16'h01FF; hit_is_new = 1'b1;
    check("full_hit_ready", hit_ready, 1'b0);
    tick(2);
    check("full_hold_hit_ready", hit_ready, 1'b0);
    check("full_no_write", writesSeen - w0, 0);
    hcmWriteReady = 1'b1;
    @(negedge clk);
    check("pop_when_full_hit_ready", hit_ready, 1'b0);
    @(posedge clk); #1;
    check("after_pop_hit_ready", hit_ready, 1'b1);
    tick();
    hit_valid = 1'b0;
    tick(12);
    check("req035_write_count", writesSeen - w0, 9);
    check("req035_queue_empty", wrQ.size(), 0);

    // Event end with three hits buffered.
    hcmWriteReady = 1'b0;
    w0 = writesSeen;
    for (int i = 0; i < 3; i++) sendHit(RB'(16'h2A0 + i), 1'(i + 1));
    pulseEventEnd();
    check("req036_phase_drain", phase, 2'd1);
    check("req036_drain_hit_ready", hit_ready, 1'b0);
    hcmWriteReady = 1'b1;
    waitPhase(2'd2, "req036_reach_read");
    check("req036_write_count", writesSeen - w0, 3);
    check("req036_read_hit_ready", hit_ready, 1'b0);
    @(posedge clk); #1;

    // event_end during READ.
    check("err_before", err_protocol, 1'b0);
    pulseEventEnd();
    check("req039_err", err_protocol, 1'b1);
    check("req039_phase_kept", phase, 2'd2);

    // Back-to-back reads of rows 0..4.
    v0 = validsSeen;
    for (int i = 0; i < 5; i++) begin
      rd_req = 1'b1; rd_row = RB'(i);
      @(negedge clk);
      check("req037_rd_ready", rd_ready, 1'b1);
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    tick(8);
    check("req037_valid_count", validsSeen - v0, 5);
    check("req037_queue_empty", rdQ.size(), 0);

    // readout_done with two reads in flight.
    v0 = validsSeen;
    r0 = resetPulses;
    rd_req = 1'b1; rd_row = 16'h0BEE; tick();
    rd_row = 16'hFACE; tick();
    rd_req = 1'b0; readout_done = 1'b1; tick();
    readout_done = 1'b0;
    check("req038_pending_rd_ready", rd_ready, 1'b0);
    check("req038_wait_inflight", phase, 2'd2);
    waitPhase(2'd3, "req038_clear");
    check("req038_hcm_reset", hif.hcm_reset, 1'b1);
    check("req038_inflight_delivered", validsSeen - v0, 2);
    waitPhase(2'd0, "req038_write");
    check("req038_event_count", event_count, 8'd1);
    check("req038_reset_pulses", resetPulses - r0, 1);
    check("req038_hit_ready", hit_ready, 1'b1);
    check("req038_err_sticky", err_protocol, 1'b1);
    @(posedge clk); #1;

    // Reset while draining.
    hcmWriteReady = 1'b0;
    for (int i = 0; i < 3; i++) sendHit(RB'(16'h0700 + i), 1'b0);
    pulseEventEnd();
    check("rst_drain_phase", phase, 2'd1);
    reset = 1'b1;
    wrQ.delete();
    hcmWriteReady = 1'b1;
    @(negedge clk);
    checkReset("rst_drain");
    @(posedge clk); #1 reset = 1'b0;
    w0 = writesSeen;
    tick(5);
    check("rst_drain_no_write", writesSeen - w0, 0);
    check("rst_drain_hit_ready", hit_ready, 1'b1);
    check("rst_drain_event_count", event_count, 8'd0);

    // rd_req outside READ is flagged and ignored.
    rd_req = 1'b1; rd_row = 16'd5; tick();
    rd_req = 1'b0;
    check("rdreq_write_err", err_protocol, 1'b1);
    check("rdreq_write_phase", phase, 2'd0);
    tick(6);
    check("final_rdq_empty", rdQ.size(), 0);
    check("final_wrq_empty", wrQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
